div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the RV32M div/divu/rem/remu ops.
//  Sits beside alu as the responder: the execute stage issues operands with a
//  valid/ready request and stalls until res_valid_o.
//  Covers all RISC-V corner cases: divide-by-zero and signed overflow.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; iteration count equals DATA_WIDTH
// PORTS
//  clk_i        in   1   clock, all state on rising edge
//  rst_ni       in   1   asynchronous active-low reset
//  req_valid_i  in   1   request valid; operands/op sampled on handshake
//  req_ready_o  out  1   unit idle, can accept a request
//  op_i         in   2   00 div, 01 divu, 10 rem, 11 remu
//  a_i          in   DW  dividend
//  b_i          in   DW  divisor
//  flush_i      in   1   abort any in-flight op (pipeline flush)
//  res_valid_o  out  1   result available in res_o
//  res_ready_i  in   1   consumer takes result
//  res_o        out  DW  quotient or remainder per latched op
//  busy_o       out  1   high in CALC or DONE
// BEHAVIOUR
//  Reset (rst_ni=0, async): state IDLE, counter 0, internal regs 0;
//   req_ready_o=1, res_valid_o=0, res_o=0, busy_o=0.
//  FSM: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE for special cases.
//  IDLE: req_ready_o=1. On req_valid_i&req_ready_o latch op, sign info,
//   |a|, |b| (signed ops take abs; unsigned pass through).
//   - b_i==0: go DONE; quotient=all ones, remainder=a_i (no sign fixup).
//   - signed op, a_i=100..0, b_i=all ones: go DONE; quotient=a_i, rem=0.
//   - otherwise: go CALC, counter=DATA_WIDTH-1, R=0, Q=|a|.
//  CALC, one bit per cycle: T={R,Q[MSB]}; Q<<=1; if T>=|b| then R=T-|b|,
//   Q[0]=1 else R=T. R is DATA_WIDTH+1 bits internally. At counter==0 go DONE.
//  Sign fixup on CALC exit: signed quotient negated iff sign(a)!=sign(b);
//   signed remainder negated iff a negative. Result register loaded from
//   quotient (div/divu) or remainder (rem/remu).
//  DONE: res_valid_o=1, res_o stable until res_valid_o&res_ready_i, then IDLE.
//  Latency (accept edge = cycle 0): normal ops res_valid_o in cycle
//   DATA_WIDTH+1; special cases in cycle 1. Next accept no earlier than the
//   cycle after result handshake (req_ready_o low in CALC/DONE).
//  flush_i: highest priority after reset; any state -> IDLE next edge,
//   res_valid_o drops, result discarded. flush_i with req_valid_i in IDLE:
//   request ignored.
//  req_valid_i while busy: ignored (ready low); operands changing mid-op have
//   no effect. res_o holds last result in IDLE (do not rely on it).
//  Reset mid-CALC/DONE: immediate return to reset values, no result emitted.
// TESTING
//  div 20,-3 -> res_valid_o at cycle 33, res_o=0xFFFFFFFA (-6); rem 20,-3 -> 2
//  divu 0xFFFFFFFF,0 -> cycle 1, res_o=0xFFFFFFFF; remu 7,0 -> res_o=7
//  div 0x80000000,0xFFFFFFFF -> cycle 1, res_o=0x80000000; rem same -> 0
//  rem -7,2 -> res_o=0xFFFFFFFF (-1); divu 0xFFFFFFFE,2 -> 0x7FFFFFFF
//  res_ready_i low 5 cycles in DONE -> res_o/res_valid_o held; req ignored
//  flush_i at cycle 10 of CALC -> IDLE next cycle, no res_valid_o; rst_ni
//   pulse mid-CALC -> req_ready_o=1, res_valid_o=0 immediately

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for RV32M div/divu/rem/remu
// One quotient bit per cycle; divide-by-zero and signed overflow resolve without iterating.
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  flush_i,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [DATA_WIDTH-1:0] res_o,
   output logic                  busy_o
);

   localparam int DW = DATA_WIDTH;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW:0]     r_q;
   logic [DW-1:0]   q_q;
   logic [DW-1:0]   b_q;
   logic            rem_sel_q;
   logic            neg_q_q;
   logic            neg_r_q;
   logic [DW-1:0]   res_q;

   logic            op_signed;
   logic            a_neg;
   logic            b_neg;
   logic [DW-1:0]   a_abs;
   logic [DW-1:0]   b_abs;
   logic            div_zero;
   logic            sgn_ovf;
   logic [DW:0]     t_w;
   logic            ge_w;
   logic [DW:0]     r_d;
   logic [DW-1:0]   q_d;
   logic [DW-1:0]   q_fix;
   logic [DW-1:0]   r_fix;

   always_comb begin
      op_signed = ~op_i[0];
      a_neg     = op_signed & a_i[DW-1];
      b_neg     = op_signed & b_i[DW-1];
      a_abs     = a_neg ? -a_i : a_i;
      b_abs     = b_neg ? -b_i : b_i;
      div_zero  = (b_i == '0);
      sgn_ovf   = op_signed && (a_i == {1'b1, {(DW-1){1'b0}}}) && (b_i == '1);

      // A set top bit in R would mean T already exceeds any DW-bit divisor.
      t_w   = {r_q[DW-1:0], q_q[DW-1]};
      ge_w  = r_q[DW] | (t_w >= {1'b0, b_q});
      r_d   = ge_w ? (t_w - {1'b0, b_q}) : t_w;
      q_d   = {q_q[DW-2:0], ge_w};
      q_fix = neg_q_q ? -q_d : q_d;
      r_fix = neg_r_q ? -r_d[DW-1:0] : r_d[DW-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         r_q       <= '0;
         q_q       <= '0;
         b_q       <= '0;
         rem_sel_q <= 1'b0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
         res_q     <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  if (div_zero) begin
                     res_q   <= op_i[1] ? a_i : '1;
                     state_q <= DONE;
                  end else if (sgn_ovf) begin
                     res_q   <= op_i[1] ? '0 : a_i;
                     state_q <= DONE;
                  end else begin
                     cnt_q     <= CW'(DW - 1);
                     r_q       <= '0;
                     q_q       <= a_abs;
                     b_q       <= b_abs;
                     rem_sel_q <= op_i[1];
                     neg_q_q   <= a_neg ^ b_neg;
                     neg_r_q   <= a_neg;
                     state_q   <= CALC;
                  end
               end
            end
            CALC: begin
               r_q   <= r_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  res_q   <= rem_sel_q ? r_fix : q_fix;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (res_ready_i) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign res_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign res_o       = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and random scoreboard bench for div_unit
// Expected results are queued at issue and popped when the result handshake arrives.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        flush = 1'b0;
   logic        res_ready = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        req_ready;
   logic        res_valid;
   logic        busy;
   logic [31:0] res;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb[$];

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .op_i(op), .a_i(a), .b_i(b), .flush_i(flush), .res_valid_o(res_valid),
      .res_ready_i(res_ready), .res_o(res), .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : x;
      case (o)
         2'b00:   return $signed(x) / $signed(y);
         2'b01:   return x / y;
         2'b10:   return $signed(x) % $signed(y);
         default: return x % y;
      endcase
   endfunction

   function automatic int lat_of(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      if (y == 0) return 1;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e);
      @(posedge clk); #1;
      check("ready_before_issue", req_ready, 1'b1);
      op = o; a = x; b = y; req_valid = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_result(input string tag, input int exp_lat, input int hold);
      int          lat;
      logic [31:0] e;
      lat = 1;
      while (!res_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      if (res_valid) begin
         check(tag, res, e);
         for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; op = 2'b01; a = 32'd9; b = 32'd3;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, res_valid, 1'b1);
            check({tag, "_hold_res"}, res, e);
            check({tag, "_hold_ready"}, req_ready, 1'b0);
         end
         req_valid = 1'b0;
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0;
         check({tag, "_ack_valid"}, res_valid, 1'b0);
         check({tag, "_ack_busy"}, busy, 1'b0);
      end
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] e, input int lat);
      start_op(o, x, y, e);
      wait_result(tag, lat, 0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          seen;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 1'b1);
      check("rst_valid", res_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_res", res, 32'h0);
      rst_n = 1'b1;

      run("div_20_m3",   2'b00, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
      run("rem_20_m3",   2'b10, 32'd20,        32'hFFFF_FFFD, 32'h0000_0002, 33);
      run("divu_by0",    2'b01, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1);
      run("remu_by0",    2'b11, 32'd7,         32'h0,         32'h0000_0007, 1);
      run("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
      run("rem_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run("divu_big",    2'b01, 32'hFFFF_FFFE, 32'd2,         32'h7FFF_FFFF, 33);
      run("rem_m7_by0",  2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1);
      run("divu_nonovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33);
      run("div_m20_m3",  2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'h0000_0006, 33);

      start_op(2'b00, 32'd100, 32'd7, 32'd14);
      wait_result("hold", 33, 5);

      start_op(2'b00, 32'd20, 32'd3, 32'd6);
      repeat (9) begin @(posedge clk); #1; end
      check("flush_busy_before", busy, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", req_ready, 1'b1);
      check("flush_valid", res_valid, 1'b0);
      check("flush_busy", busy, 1'b0);
      if (sb.size() != 0) void'(sb.pop_front());
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (res_valid) seen++; end
      check("flush_no_result", seen, 0);

      op = 2'b01; a = 32'd50; b = 32'd5; req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flush_req_ready", req_ready, 1'b1);
      check("flush_req_busy", busy, 1'b0);

      start_op(2'b01, 32'd1000, 32'd9, 32'd111);
      repeat (5) begin @(posedge clk); #1; end
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_ready", req_ready, 1'b1);
      check("midrst_valid", res_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_res", res, 32'h0);
      if (sb.size() != 0) void'(sb.pop_front());
      @(posedge clk); #1;
      rst_n = 1'b1;

      run("post_rst_remu", 2'b11, 32'd1000, 32'd9, 32'd1, 33);

      for (int i = 0; i < 10; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
         if (i % 4 == 1) ra = -ra;
         run("random", ro, ra, rb, model(ro, ra, rb), lat_of(ro, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
